// File: rtl/axi4_lite_regbank_pkg.sv
// Shared constants and helpers for the AXI4-Lite register bank.
// Response codes, byte-strobe width and word-index extraction.
package axi4_lite_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Number of byte lanes for a data word of the given width.
   function automatic int strb_width(input int data_size);
      return data_size / 8;
   endfunction

   // Word index of a byte address; the two byte-offset bits are dropped.
   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

endpackage

// File: rtl/axi4_lite_regbank_skid.sv
// Two-entry skid buffer: registered upstream ready, full throughput.
// Used on every AXI channel when AXI4_LITE_REGBANK_SKID_EN is defined.
module axi4_lite_regbank_skid #(
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic             s_ready_reg;
   logic             m_valid_reg;
   logic [WIDTH-1:0] m_data_reg;
   logic             skid_valid_reg;
   logic             skid_valid_next;
   logic [WIDTH-1:0] skid_data_reg;
   logic             s_fire;
   logic             m_free;

   assign s_fire  = s_valid & s_ready_reg;
   assign m_free  = ~m_valid_reg | m_ready;
   assign s_ready = s_ready_reg;
   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;

   // Skid entry fills when the output stalls on an accepted beat, drains when the output frees up.
   always_comb begin
      skid_valid_next = skid_valid_reg;
      if (m_free) begin
         skid_valid_next = 1'b0;
      end else if (s_fire) begin
         skid_valid_next = 1'b1;
      end
   end

   // Output stage and skid storage; upstream ready is simply "skid entry will be empty".
   always_ff @(posedge aclk) begin
      if (areset) begin
         s_ready_reg    <= 1'b0;
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else begin
         skid_valid_reg <= skid_valid_next;
         s_ready_reg    <= ~skid_valid_next;
         if (m_free) begin
            if (skid_valid_reg) begin
               m_valid_reg <= 1'b1;
               m_data_reg  <= skid_data_reg;
            end else begin
               m_valid_reg <= s_fire;
               if (s_fire) begin
                  m_data_reg <= s_data;
               end
            end
         end else if (s_fire) begin
            skid_data_reg <= s_data;
         end
      end
   end

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with byte strobes and hardware-sourced read-only words.
// Optional macro AXI4_LITE_REGBANK_SKID_EN inserts a skid stage on AR, AW, W, R and B.
module axi4_lite_regbank
   import axi4_lite_regbank_pkg::*;
#(
   parameter int                   ADDRESS_SIZE = 5,
   parameter int                   DATA_SIZE    = 32,
   parameter int                   REGISTERS    = 8,
   parameter logic [REGISTERS-1:0] RO_MASK      = '0,
   parameter logic [DATA_SIZE-1:0] INIT_VALUE   = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDRESS_SIZE-1:0]        s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_SIZE-1:0]           s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   input  logic [ADDRESS_SIZE-1:0]        s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_SIZE-1:0]           s_axi_wdata,
   input  logic [DATA_SIZE/8-1:0]         s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   output logic [REGISTERS*DATA_SIZE-1:0] regs_o,
   input  logic [REGISTERS*DATA_SIZE-1:0] hw_status_i,
   output logic [REGISTERS-1:0]           wr_pulse_o
);

   localparam int STRB_W = strb_width(DATA_SIZE);

   // Core-side channel signals (directly the ports, or the far side of the skid stages)
   logic [ADDRESS_SIZE-1:0] ar_addr;
   logic                    ar_valid;
   logic                    ar_ready;
   logic [ADDRESS_SIZE-1:0] aw_addr;
   logic                    aw_valid;
   logic                    aw_ready;
   logic [DATA_SIZE-1:0]    w_data;
   logic [STRB_W-1:0]       w_strb;
   logic                    w_valid;
   logic                    w_ready;
   logic                    r_ready;
   logic                    b_ready;

   // Write-side state
   logic                    aw_held_reg;
   logic [ADDRESS_SIZE-1:0] aw_addr_reg;
   logic                    w_held_reg;
   logic [DATA_SIZE-1:0]    w_data_reg;
   logic [STRB_W-1:0]       w_strb_reg;
   logic                    b_valid_reg;
   logic [1:0]              b_resp_reg;
   logic [REGISTERS-1:0]    wr_pulse_reg;
   logic [REGISTERS-1:0]    wr_hit;
   logic                    commit;
   logic [31:0]             aw_idx;

   // Read-side state
   logic                    r_valid_reg;
   logic [DATA_SIZE-1:0]    r_data_reg;
   logic [1:0]              r_resp_reg;
   logic [31:0]             ar_idx;
   logic [DATA_SIZE-1:0]    rd_word;
   logic                    rd_hit;

   logic [DATA_SIZE-1:0]    word_val [REGISTERS];

`ifdef AXI4_LITE_REGBANK_SKID_EN
   logic [DATA_SIZE+STRB_W-1:0] w_bus;
   logic [DATA_SIZE+1:0]        r_bus;

   axi4_lite_regbank_skid #(.WIDTH(ADDRESS_SIZE)) u_ar_skid (
      .aclk    (aclk),
      .areset  (areset),
      .s_data  (s_axi_araddr),
      .s_valid (s_axi_arvalid),
      .s_ready (s_axi_arready),
      .m_data  (ar_addr),
      .m_valid (ar_valid),
      .m_ready (ar_ready)
   );

   axi4_lite_regbank_skid #(.WIDTH(ADDRESS_SIZE)) u_aw_skid (
      .aclk    (aclk),
      .areset  (areset),
      .s_data  (s_axi_awaddr),
      .s_valid (s_axi_awvalid),
      .s_ready (s_axi_awready),
      .m_data  (aw_addr),
      .m_valid (aw_valid),
      .m_ready (aw_ready)
   );

   axi4_lite_regbank_skid #(.WIDTH(DATA_SIZE + STRB_W)) u_w_skid (
      .aclk    (aclk),
      .areset  (areset),
      .s_data  ({s_axi_wstrb, s_axi_wdata}),
      .s_valid (s_axi_wvalid),
      .s_ready (s_axi_wready),
      .m_data  (w_bus),
      .m_valid (w_valid),
      .m_ready (w_ready)
   );
   assign {w_strb, w_data} = w_bus;

   axi4_lite_regbank_skid #(.WIDTH(DATA_SIZE + 2)) u_r_skid (
      .aclk    (aclk),
      .areset  (areset),
      .s_data  ({r_resp_reg, r_data_reg}),
      .s_valid (r_valid_reg),
      .s_ready (r_ready),
      .m_data  (r_bus),
      .m_valid (s_axi_rvalid),
      .m_ready (s_axi_rready)
   );
   assign {s_axi_rresp, s_axi_rdata} = r_bus;

   axi4_lite_regbank_skid #(.WIDTH(2)) u_b_skid (
      .aclk    (aclk),
      .areset  (areset),
      .s_data  (b_resp_reg),
      .s_valid (b_valid_reg),
      .s_ready (b_ready),
      .m_data  (s_axi_bresp),
      .m_valid (s_axi_bvalid),
      .m_ready (s_axi_bready)
   );
`else
   assign ar_addr       = s_axi_araddr;
   assign ar_valid      = s_axi_arvalid;
   assign s_axi_arready = ar_ready;
   assign aw_addr       = s_axi_awaddr;
   assign aw_valid      = s_axi_awvalid;
   assign s_axi_awready = aw_ready;
   assign w_data        = s_axi_wdata;
   assign w_strb        = s_axi_wstrb;
   assign w_valid       = s_axi_wvalid;
   assign s_axi_wready  = w_ready;
   assign s_axi_rdata   = r_data_reg;
   assign s_axi_rresp   = r_resp_reg;
   assign s_axi_rvalid  = r_valid_reg;
   assign r_ready       = s_axi_rready;
   assign s_axi_bresp   = b_resp_reg;
   assign s_axi_bvalid  = b_valid_reg;
   assign b_ready       = s_axi_bready;
`endif

   // Readies are forced low for the whole time reset is asserted.
   assign aw_ready   = ~areset & ~aw_held_reg;
   assign w_ready    = ~areset & ~w_held_reg;
   assign ar_ready   = ~areset & (~r_valid_reg | r_ready);

   assign aw_idx     = word_index(32'(aw_addr_reg));
   assign ar_idx     = word_index(32'(ar_addr));
   assign commit     = aw_held_reg & w_held_reg & (~b_valid_reg | b_ready);
   assign wr_pulse_o = wr_pulse_reg;

   // Per-word storage: read-only words mirror hardware, read/write words take strobed bytes on commit.
   for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_word
      assign wr_hit[gi] = ~RO_MASK[gi] & (aw_idx == 32'(gi));
      assign regs_o[gi*DATA_SIZE +: DATA_SIZE] = word_val[gi];

      if (RO_MASK[gi]) begin : g_ro
         assign word_val[gi] = hw_status_i[gi*DATA_SIZE +: DATA_SIZE];
      end else begin : g_rw
         logic [DATA_SIZE-1:0] word_reg;
         logic                 unused_hw;

         assign unused_hw    = ^hw_status_i[gi*DATA_SIZE +: DATA_SIZE];
         assign word_val[gi] = word_reg;

         // Byte-lane update of this word on a committed write that targets it.
         always_ff @(posedge aclk) begin
            if (areset) begin
               word_reg <= INIT_VALUE;
            end else if (commit && wr_hit[gi]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (w_strb_reg[b]) begin
                     word_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // AW/W holding registers, commit, write response and the one-cycle write pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held_reg  <= 1'b0;
         aw_addr_reg  <= '0;
         w_held_reg   <= 1'b0;
         w_data_reg   <= '0;
         w_strb_reg   <= '0;
         b_valid_reg  <= 1'b0;
         b_resp_reg   <= RESP_OKAY;
         wr_pulse_reg <= '0;
      end else begin
         wr_pulse_reg <= '0;
         if (aw_valid && aw_ready) begin
            aw_held_reg <= 1'b1;
            aw_addr_reg <= aw_addr;
         end
         if (w_valid && w_ready) begin
            w_held_reg <= 1'b1;
            w_data_reg <= w_data;
            w_strb_reg <= w_strb;
         end
         if (commit) begin
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            b_valid_reg  <= 1'b1;
            b_resp_reg   <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
            wr_pulse_reg <= wr_hit;
         end else if (b_ready) begin
            b_valid_reg <= 1'b0;
         end
      end
   end

   // Read mux; an index with no matching word yields zero and flags an error.
   always_comb begin
      rd_word = '0;
      rd_hit  = 1'b0;
      for (int i = 0; i < REGISTERS; i++) begin
         if (ar_idx == 32'(i)) begin
            rd_word = word_val[i];
            rd_hit  = 1'b1;
         end
      end
   end

   // Read data register: loaded on the AR handshake, held until the R handshake.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_valid_reg <= 1'b0;
         r_data_reg  <= '0;
         r_resp_reg  <= RESP_OKAY;
      end else if (ar_valid && ar_ready) begin
         r_valid_reg <= 1'b1;
         r_data_reg  <= rd_word;
         r_resp_reg  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (r_ready) begin
         r_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed self-checking bench for axi4_lite_regbank (8 words, word 7 read-only).
// A 6-bit address is used so that indices past the last word can be exercised.
module tb_axi4_lite_regbank;

   localparam int AW      = 6;
   localparam int DW      = 32;
   localparam int NREG    = 8;
   localparam int TIMEOUT = 40;

   logic               aclk = 1'b0;
   logic               areset;
   logic [AW-1:0]      s_axi_araddr;
   logic               s_axi_arvalid;
   logic               s_axi_arready;
   logic [DW-1:0]      s_axi_rdata;
   logic [1:0]         s_axi_rresp;
   logic               s_axi_rvalid;
   logic               s_axi_rready;
   logic [AW-1:0]      s_axi_awaddr;
   logic               s_axi_awvalid;
   logic               s_axi_awready;
   logic [DW-1:0]      s_axi_wdata;
   logic [DW/8-1:0]    s_axi_wstrb;
   logic               s_axi_wvalid;
   logic               s_axi_wready;
   logic [1:0]         s_axi_bresp;
   logic               s_axi_bvalid;
   logic               s_axi_bready;
   logic [NREG*DW-1:0] regs_o;
   logic [NREG*DW-1:0] hw_status_i;
   logic [NREG-1:0]    wr_pulse_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  pulse_or = '0;
   int          pulse_cycles = 0;

   always #5 aclk = ~aclk;

   axi4_lite_regbank #(
      .ADDRESS_SIZE (AW),
      .DATA_SIZE    (DW),
      .REGISTERS    (NREG),
      .RO_MASK      (8'b1000_0000),
      .INIT_VALUE   (32'h0)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .regs_o        (regs_o),
      .hw_status_i   (hw_status_i),
      .wr_pulse_o    (wr_pulse_o)
   );

   // Accumulate write pulses once per cycle
   always @(negedge aclk) begin
      if (wr_pulse_o != '0) begin
         pulse_or     = pulse_or | wr_pulse_o;
         pulse_cycles = pulse_cycles + 1;
      end
   end

   task automatic clear_pulses();
      pulse_or     = '0;
      pulse_cycles = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // Write engine: optionally drives AW and/or W, optionally waits for the B beat.
   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit send_aw, input bit send_w, input bit wait_b,
                            output logic [1:0] resp, output bit ok);
      bit aw_pend, w_pend, b_pend, aw_hs, w_hs, b_hs;
      aw_pend = send_aw;
      w_pend  = send_w;
      b_pend  = wait_b;
      resp    = 2'b11;
      s_axi_awaddr  = addr;
      s_axi_awvalid = send_aw;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = send_w;
      s_axi_bready  = wait_b;
      for (int c = 0; c < TIMEOUT && (aw_pend || w_pend || b_pend); c++) begin
         @(negedge aclk);
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         b_hs  = s_axi_bvalid && s_axi_bready;
         if (b_hs) resp = s_axi_bresp;
         @(posedge aclk);
         #1;
         if (aw_hs) begin s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_hs)  begin s_axi_wvalid  = 1'b0; w_pend  = 1'b0; end
         if (b_hs)  begin s_axi_bready  = 1'b0; b_pend  = 1'b0; end
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      ok = !(aw_pend || w_pend || b_pend);
      $display("[TB] WR addr=0x%02h data=0x%08h strb=%b aw=%0d w=%0d b=%0d resp=%b done=%0d",
               addr, data, strb, send_aw, send_w, wait_b, resp, ok);
   endtask

   // Read engine: one AR, one R beat with rready held high.
   task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
      bit ar_pend, r_pend, ar_hs, r_hs;
      ar_pend = 1'b1;
      r_pend  = 1'b1;
      data    = 'x;
      resp    = 2'b11;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      for (int c = 0; c < TIMEOUT && (ar_pend || r_pend); c++) begin
         @(negedge aclk);
         ar_hs = s_axi_arvalid && s_axi_arready;
         r_hs  = s_axi_rvalid && s_axi_rready;
         if (r_hs) begin data = s_axi_rdata; resp = s_axi_rresp; end
         @(posedge aclk);
         #1;
         if (ar_hs) begin s_axi_arvalid = 1'b0; ar_pend = 1'b0; end
         if (r_hs)  begin s_axi_rready  = 1'b0; r_pend  = 1'b0; end
      end
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      ok = !(ar_pend || r_pend);
      $display("[TB] RD addr=0x%02h data=0x%08h resp=%b done=%0d", addr, data, resp, ok);
   endtask

   task automatic test_reset();
      areset        = 1'b1;
      s_axi_araddr  = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      s_axi_awaddr  = '0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      n_tests++;
      if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_readies: got %b, expected 000", {s_axi_arready, s_axi_awready, s_axi_wready});
      end
      n_tests++;
      if ({s_axi_rvalid, s_axi_bvalid, wr_pulse_o} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_valids: got %b, expected 0", {s_axi_rvalid, s_axi_bvalid, wr_pulse_o});
      end
      n_tests++;
      if ({s_axi_rdata, s_axi_rresp, s_axi_bresp} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_resp_data: got %h, expected 0", {s_axi_rdata, s_axi_rresp, s_axi_bresp});
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      n_tests++;
      if (regs_o[0 +: 7*DW] !== '0) begin
         n_fail++;
         $display("FAIL reset_rw_words: got %h, expected 0", regs_o[0 +: 7*DW]);
      end
      n_tests++;
      if (regs_o[7*DW +: DW] !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL reset_ro_word: got %h, expected cafef00d", regs_o[7*DW +: DW]);
      end
      @(posedge aclk);
      #1;
      cycles(2);
   endtask

   task automatic test_basic_write();
      logic [1:0]  resp;
      logic [31:0] data;
      bit          ok;
      clear_pulses();
      axi_write(6'h04, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b1, resp, ok);
      n_tests++;
      if (!ok || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL wr1_bresp: got %b (done=%0d), expected 00", resp, ok);
      end
      cycles(3);
      n_tests++;
      if (regs_o[1*DW +: DW] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr1_word1: got %h, expected deadbeef", regs_o[1*DW +: DW]);
      end
      n_tests++;
      if (pulse_or !== 8'h02 || pulse_cycles != 1) begin
         n_fail++;
         $display("FAIL wr1_pulse: got %h over %0d cycles, expected 02 over 1", pulse_or, pulse_cycles);
      end
      axi_read(6'h04, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL rd1_word1: got %h/%b, expected deadbeef/00", data, resp);
      end
      // Low address bits are ignored
      axi_read(6'h07, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL rd1_unaligned: got %h/%b, expected deadbeef/00", data, resp);
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp;
      bit         ok;
      bit         saw_b;
      clear_pulses();
      axi_write(6'h08, 32'h11223344, 4'b0101, 1'b0, 1'b1, 1'b0, resp, ok);
      saw_b = 1'b0;
      repeat (3) begin
         @(negedge aclk);
         if (s_axi_bvalid) saw_b = 1'b1;
      end
      @(posedge aclk);
      #1;
      n_tests++;
      if (!ok || saw_b || regs_o[2*DW +: DW] !== 32'h0) begin
         n_fail++;
         $display("FAIL wfirst_no_commit: got bvalid=%0d word2=%h (w done=%0d), expected 0/00000000", saw_b, regs_o[2*DW +: DW], ok);
      end
      axi_write(6'h08, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, resp, ok);
      n_tests++;
      if (!ok || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL wfirst_bresp: got %b (done=%0d), expected 00", resp, ok);
      end
      cycles(2);
      n_tests++;
      if (regs_o[2*DW +: DW] !== 32'h00220044) begin
         n_fail++;
         $display("FAIL wfirst_word2: got %h, expected 00220044", regs_o[2*DW +: DW]);
      end
      n_tests++;
      if (pulse_or !== 8'h04 || pulse_cycles != 1) begin
         n_fail++;
         $display("FAIL wfirst_pulse: got %h over %0d cycles, expected 04 over 1", pulse_or, pulse_cycles);
      end
   endtask

   task automatic test_ro_word();
      logic [1:0]  resp;
      logic [31:0] data;
      bit          ok;
      clear_pulses();
      axi_write(6'h1C, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, resp, ok);
      n_tests++;
      if (!ok || resp !== 2'b10) begin
         n_fail++;
         $display("FAIL ro_bresp: got %b (done=%0d), expected 10", resp, ok);
      end
      cycles(3);
      n_tests++;
      if (pulse_cycles != 0) begin
         n_fail++;
         $display("FAIL ro_pulse: got %0d pulse cycles (%h), expected 0", pulse_cycles, pulse_or);
      end
      axi_read(6'h1C, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'hCAFEF00D || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL ro_read: got %h/%b, expected cafef00d/00", data, resp);
      end
      // RW word 0 must not reflect its hardware slice
      axi_read(6'h00, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'h0 || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL rw_not_hw: got %h/%b, expected 00000000/00", data, resp);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0]        resp;
      logic [31:0]       data;
      bit                ok;
      logic [NREG*DW-1:0] exp_regs;
      axi_read(6'h20, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'h0 || resp !== 2'b10) begin
         n_fail++;
         $display("FAIL oor_read20: got %h/%b, expected 00000000/10", data, resp);
      end
      axi_read(6'h3C, data, resp, ok);
      n_tests++;
      if (!ok || data !== 32'h0 || resp !== 2'b10) begin
         n_fail++;
         $display("FAIL oor_read3c: got %h/%b, expected 00000000/10", data, resp);
      end
      clear_pulses();
      axi_write(6'h20, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1'b1, resp, ok);
      n_tests++;
      if (!ok || resp !== 2'b10) begin
         n_fail++;
         $display("FAIL oor_bresp: got %b (done=%0d), expected 10", resp, ok);
      end
      cycles(3);
      exp_regs = '0;
      exp_regs[1*DW +: DW] = 32'hDEADBEEF;
      exp_regs[2*DW +: DW] = 32'h00220044;
      exp_regs[7*DW +: DW] = 32'hCAFEF00D;
      n_tests++;
      if (regs_o !== exp_regs || pulse_cycles != 0) begin
         n_fail++;
         $display("FAIL oor_regs: got %h pulses=%0d, expected %h pulses=0", regs_o, pulse_cycles, exp_regs);
      end
   endtask

   task automatic test_b_backpressure();
      logic [1:0] resp;
      logic [1:0] beat_resp [2];
      bit         ok_a, ok_b, stuck;
      int         beats;
      clear_pulses();
      axi_write(6'h0C, 32'h000000A1, 4'hF, 1'b1, 1'b1, 1'b0, resp, ok_a);
      axi_write(6'h1C, 32'h000000B2, 4'hF, 1'b1, 1'b1, 1'b0, resp, ok_b);
      stuck = 1'b1;
      repeat (4) begin
         @(negedge aclk);
         if (!s_axi_bvalid || s_axi_bresp !== 2'b00) stuck = 1'b0;
      end
      @(posedge aclk);
      #1;
      n_tests++;
      if (!ok_a || !ok_b || !stuck) begin
         n_fail++;
         $display("FAIL bp_hold: got accept=%0d/%0d bvalid_held=%0d, expected 1/1/1", ok_a, ok_b, stuck);
      end
      s_axi_bready = 1'b1;
      beats = 0;
      beat_resp[0] = 2'b11;
      beat_resp[1] = 2'b11;
      for (int c = 0; c < 12; c++) begin
         @(negedge aclk);
         if (s_axi_bvalid && s_axi_bready) begin
            if (beats < 2) beat_resp[beats] = s_axi_bresp;
            beats++;
         end
         @(posedge aclk);
         #1;
      end
      s_axi_bready = 1'b0;
      $display("[TB] B drain beats=%0d resp0=%b resp1=%b", beats, beat_resp[0], beat_resp[1]);
      n_tests++;
      if (beats != 2) begin
         n_fail++;
         $display("FAIL bp_beats: got %0d beats, expected 2", beats);
      end
      n_tests++;
      if (beat_resp[0] !== 2'b00 || beat_resp[1] !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_order: got %b,%b, expected 00,10", beat_resp[0], beat_resp[1]);
      end
      n_tests++;
      if (regs_o[3*DW +: DW] !== 32'h000000A1 || pulse_or !== 8'h08 || pulse_cycles != 1) begin
         n_fail++;
         $display("FAIL bp_word3: got %h pulse %h/%0d, expected 000000a1 pulse 08/1", regs_o[3*DW +: DW], pulse_or, pulse_cycles);
      end
   endtask

   task automatic test_reset_midflight();
      logic [1:0] resp;
      bit         ar_done, rv_seen, ok, saw_b;
      s_axi_araddr  = 6'h04;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b0;
      ar_done = 1'b0;
      rv_seen = 1'b0;
      for (int c = 0; c < TIMEOUT && !rv_seen; c++) begin
         @(negedge aclk);
         if (s_axi_arvalid && s_axi_arready) ar_done = 1'b1;
         rv_seen = s_axi_rvalid;
         @(posedge aclk);
         #1;
         if (ar_done) s_axi_arvalid = 1'b0;
      end
      s_axi_arvalid = 1'b0;
      axi_write(6'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, resp, ok);
      cycles(1);
      n_tests++;
      if (!ar_done || !rv_seen || !ok) begin
         n_fail++;
         $display("FAIL mid_setup: got ar=%0d rvalid=%0d aw=%0d, expected 1/1/1", ar_done, rv_seen, ok);
      end
      areset = 1'b1;
      @(posedge aclk);
      #1;
      @(negedge aclk);
      n_tests++;
      if (s_axi_rvalid !== 1'b0 || s_axi_bvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_valids: got rvalid=%b bvalid=%b, expected 0/0", s_axi_rvalid, s_axi_bvalid);
      end
      n_tests++;
      if (regs_o[0 +: 7*DW] !== '0 || regs_o[7*DW +: DW] !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL mid_words: got %h, expected rw words 0 and word7 cafef00d", regs_o);
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
      cycles(2);
      clear_pulses();
      axi_write(6'h00, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, resp, ok);
      saw_b = 1'b0;
      repeat (8) begin
         @(negedge aclk);
         if (s_axi_bvalid) saw_b = 1'b1;
      end
      @(posedge aclk);
      #1;
      n_tests++;
      if (!ok || saw_b || pulse_cycles != 0 || regs_o[0 +: DW] !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_dropped_aw: got w=%0d bvalid=%0d pulses=%0d word0=%h, expected 1/0/0/00000000",
                  ok, saw_b, pulse_cycles, regs_o[0 +: DW]);
      end
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) begin
         hw_status_i[i*DW +: DW] = 32'hA5A50000 | 32'(i);
      end
      hw_status_i[7*DW +: DW] = 32'hCAFEF00D;
      test_reset();
      test_basic_write();
      test_w_before_aw();
      test_ro_word();
      test_out_of_range();
      test_b_backpressure();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
